exec_stage: RTL and testbench

- Execute stage; sits directly downstream of the decode/execute pipeline buffer and consumes its registered outputs.
- Computes the 16-bit ALU result and holds the condition-code register (Z, N, C). Handles SETC/CLRC and resolves conditional and unconditional branches.
- On a taken branch, drives a multi-cycle flush to the front end.
- Results are registered into the execute/memory boundary with one-cycle latency.

---
 rtl/exec_pkg.sv | 28 ++
 rtl/exec_if.sv | 47 ++++
 rtl/exec_alu.sv | 95 +++++++++
 rtl/exec_stage.sv | 137 +++++++++++++
 tb/tb_exec_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, branch conditions
// and condition-code register bit positions.
package exec_pkg;

   localparam logic [3:0] ALU_PASSA = 4'd0;
   localparam logic [3:0] ALU_NOTA  = 4'd1;
   localparam logic [3:0] ALU_INC   = 4'd2;
   localparam logic [3:0] ALU_DEC   = 4'd3;
   localparam logic [3:0] ALU_ADD   = 4'd4;
   localparam logic [3:0] ALU_SUB   = 4'd5;
   localparam logic [3:0] ALU_AND   = 4'd6;
   localparam logic [3:0] ALU_OR    = 4'd7;
   localparam logic [3:0] ALU_SHL   = 4'd8;
   localparam logic [3:0] ALU_SHR   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef enum logic [1:0] {
      BR_JZ  = 2'b00,
      BR_JN  = 2'b01,
      BR_JC  = 2'b10,
      BR_JMP = 2'b11
   } br_cond_e;

   localparam int CCR_Z = 0;
   localparam int CCR_N = 1;
   localparam int CCR_C = 2;

endpackage

// File: rtl/exec_if.sv
// Decode/execute buffer outputs into the execute stage and the execute/memory
// boundary plus branch/flush signals coming back out.
interface exec_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] Reg1;
   logic [DATA_W-1:0] Reg2;
   logic [DATA_W-1:0] instr;
   logic [3:0]        aluSignals;
   logic              ALU_src;
   logic              Branch;
   logic [4:0]        Instruction;
   logic              SetC;
   logic              CLRC;
   logic              RW;
   logic              MR;
   logic              MW;
   logic              MTR;
   logic [2:0]        RegDestination;

   logic [DATA_W-1:0] ResultOut;
   logic [DATA_W-1:0] StoreDataOut;
   logic              RWOut;
   logic              MROut;
   logic              MWOut;
   logic              MTROut;
   logic [2:0]        RegDestinationOut;
   logic [2:0]        CCR;
   logic              BranchTaken;
   logic [DATA_W-1:0] BranchTarget;
   logic              Flush;

   modport master (
      output Reg1, Reg2, instr, aluSignals, ALU_src, Branch, Instruction,
             SetC, CLRC, RW, MR, MW, MTR, RegDestination,
      input  ResultOut, StoreDataOut, RWOut, MROut, MWOut, MTROut,
             RegDestinationOut, CCR, BranchTaken, BranchTarget, Flush
   );

   modport slave (
      input  Reg1, Reg2, instr, aluSignals, ALU_src, Branch, Instruction,
             SetC, CLRC, RW, MR, MW, MTR, RegDestination,
      output ResultOut, StoreDataOut, RWOut, MROut, MWOut, MTROut,
             RegDestinationOut, CCR, BranchTaken, BranchTarget, Flush
   );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: result plus Z/N/C candidates and per-op flag-update enables.
module exec_alu
   import exec_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              neg,
   output logic              carry,
   output logic              carry_valid,
   output logic              zn_valid
);

   localparam int WW = DATA_W + 1;

   logic [WW-1:0] wide;
   logic [3:0]    sh;

   assign sh = b[3:0];

   // Shifts run one bit wider so the last bit shifted out lands in an extra position.
   always_comb begin
      wide        = '0;
      result      = a;
      carry       = 1'b0;
      carry_valid = 1'b0;
      zn_valid    = 1'b0;
      case (op)
         ALU_NOTA: begin
            result   = ~a;
            zn_valid = 1'b1;
         end
         ALU_INC: begin
            wide        = {1'b0, a} + WW'(1);
            result      = wide[DATA_W-1:0];
            carry       = wide[DATA_W];
            carry_valid = 1'b1;
            zn_valid    = 1'b1;
         end
         ALU_DEC: begin
            wide        = {1'b0, a} - WW'(1);
            result      = wide[DATA_W-1:0];
            carry       = wide[DATA_W];
            carry_valid = 1'b1;
            zn_valid    = 1'b1;
         end
         ALU_ADD: begin
            wide        = {1'b0, a} + {1'b0, b};
            result      = wide[DATA_W-1:0];
            carry       = wide[DATA_W];
            carry_valid = 1'b1;
            zn_valid    = 1'b1;
         end
         ALU_SUB: begin
            wide        = {1'b0, a} - {1'b0, b};
            result      = wide[DATA_W-1:0];
            carry       = wide[DATA_W];
            carry_valid = 1'b1;
            zn_valid    = 1'b1;
         end
         ALU_AND: begin
            result   = a & b;
            zn_valid = 1'b1;
         end
         ALU_OR: begin
            result   = a | b;
            zn_valid = 1'b1;
         end
         ALU_SHL: begin
            wide        = {1'b0, a} << sh;
            result      = wide[DATA_W-1:0];
            carry       = wide[DATA_W];
            carry_valid = (sh != 4'd0);
            zn_valid    = 1'b1;
         end
         ALU_SHR: begin
            wide        = {a, 1'b0} >> sh;
            result      = wide[DATA_W:1];
            carry       = wide[0];
            carry_valid = (sh != 4'd0);
            zn_valid    = 1'b1;
         end
         ALU_PASSB: result = b;
         default:   result = a;
      endcase
   end

   assign zero = (result == '0);
   assign neg  = result[DATA_W-1];

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, condition-code register, branch resolution with a
// multi-cycle front-end flush, and the execute/memory pipeline registers.
module exec_stage
   import exec_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input logic   Clk,
   input logic   Rst,
   exec_if.slave bus
);

   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] alu_res;
   logic              alu_zero;
   logic              alu_neg;
   logic              alu_carry;
   logic              alu_cv;
   logic              alu_znv;

   logic [1:0]        flush_cnt;
   logic              flush;
   logic              cond_met;
   logic              branch_taken;
   br_cond_e          br_cond;
   logic [2:0]        ccr_q;
   logic [2:0]        ccr_next;

   logic [DATA_W-1:0] result_p1;
   logic [DATA_W-1:0] store_p1;
   logic              rw_p1;
   logic              mr_p1;
   logic              mw_p1;
   logic              mtr_p1;
   logic [2:0]        rd_p1;

   logic              unused_instr;
   assign unused_instr = ^bus.Instruction[4:2];

   assign opb = bus.ALU_src ? bus.instr : bus.Reg2;

   exec_alu #(.DATA_W(DATA_W)) u_alu (
      .a           (bus.Reg1),
      .b           (opb),
      .op          (bus.aluSignals),
      .result      (alu_res),
      .zero        (alu_zero),
      .neg         (alu_neg),
      .carry       (alu_carry),
      .carry_valid (alu_cv),
      .zn_valid    (alu_znv)
   );

   assign flush   = (flush_cnt != 2'd0);
   assign br_cond = br_cond_e'(bus.Instruction[1:0]);

   // Branch decisions look only at flags committed on earlier edges.
   always_comb begin
      cond_met = 1'b0;
      case (br_cond)
         BR_JZ:   cond_met = ccr_q[CCR_Z];
         BR_JN:   cond_met = ccr_q[CCR_N];
         BR_JC:   cond_met = ccr_q[CCR_C];
         BR_JMP:  cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   assign branch_taken = bus.Branch & ~flush & cond_met;

   always_comb begin
      ccr_next = ccr_q;
      if (!flush) begin
         if (alu_znv) begin
            ccr_next[CCR_Z] = alu_zero;
            ccr_next[CCR_N] = alu_neg;
         end
         // SetC and CLRC together are illegal; carry simply holds.
         if (bus.SetC && !bus.CLRC)
            ccr_next[CCR_C] = 1'b1;
         else if (bus.CLRC && !bus.SetC)
            ccr_next[CCR_C] = 1'b0;
         else if (!bus.SetC && alu_cv)
            ccr_next[CCR_C] = alu_carry;
         if (branch_taken) begin
            case (br_cond)
               BR_JZ:   ccr_next[CCR_Z] = 1'b0;
               BR_JN:   ccr_next[CCR_N] = 1'b0;
               BR_JC:   ccr_next[CCR_C] = 1'b0;
               default: ;
            endcase
         end
      end
   end

   // ---- execute / memory boundary (p1) ----
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         flush_cnt <= 2'd0;
         ccr_q     <= 3'b000;
         result_p1 <= '0;
         store_p1  <= '0;
         rw_p1     <= 1'b0;
         mr_p1     <= 1'b0;
         mw_p1     <= 1'b0;
         mtr_p1    <= 1'b0;
         rd_p1     <= 3'd0;
      end else begin
         if (branch_taken)
            flush_cnt <= 2'(FLUSH_CYCLES);
         else if (flush)
            flush_cnt <= flush_cnt - 2'd1;
         ccr_q     <= ccr_next;
         result_p1 <= alu_res;
         store_p1  <= bus.Reg2;
         rw_p1     <= bus.RW & ~flush;
         mr_p1     <= bus.MR & ~flush;
         mw_p1     <= bus.MW & ~flush;
         mtr_p1    <= bus.MTR;
         rd_p1     <= bus.RegDestination;
      end
   end

   assign bus.ResultOut         = result_p1;
   assign bus.StoreDataOut      = store_p1;
   assign bus.RWOut             = rw_p1;
   assign bus.MROut             = mr_p1;
   assign bus.MWOut             = mw_p1;
   assign bus.MTROut            = mtr_p1;
   assign bus.RegDestinationOut = rd_p1;
   assign bus.CCR               = ccr_q;
   assign bus.BranchTaken       = branch_taken;
   assign bus.BranchTarget      = bus.Reg1;
   assign bus.Flush             = flush;

endmodule

// File: tb/tb_exec_stage.sv
// Directed and randomized checks of exec_stage against an arithmetic reference model.
module tb_exec_stage;
   import exec_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exec_if #(.DATA_W(16)) bus();

   exec_stage #(.DATA_W(16), .FLUSH_CYCLES(2)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference state
   bit mz, mn, mc;
   int mcnt;
   int e_res, e_store, e_rd;
   bit e_rw, e_mr, e_mw, e_mtr;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mz = 0; mn = 0; mc = 0; mcnt = 0;
      e_res = 0; e_store = 0; e_rd = 0;
      e_rw = 0; e_mr = 0; e_mw = 0; e_mtr = 0;
   endtask

   task automatic nop();
      bus.Reg1 = 16'h0; bus.Reg2 = 16'h0; bus.instr = 16'h0;
      bus.aluSignals = ALU_PASSA; bus.ALU_src = 1'b0;
      bus.Branch = 1'b0; bus.Instruction = 5'd0;
      bus.SetC = 1'b0; bus.CLRC = 1'b0;
      bus.RW = 1'b0; bus.MR = 1'b0; bus.MW = 1'b0; bus.MTR = 1'b0;
      bus.RegDestination = 3'd0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_res"},   bus.ResultOut, 16'(e_res));
      chk({tag, "_store"}, bus.StoreDataOut, 16'(e_store));
      chk({tag, "_ctl"},   16'({bus.RWOut, bus.MROut, bus.MWOut, bus.MTROut}),
          16'({e_rw, e_mr, e_mw, e_mtr}));
      chk({tag, "_rd"},    16'(bus.RegDestinationOut), 16'(e_rd));
      chk({tag, "_ccr"},   16'(bus.CCR), 16'({mc, mn, mz}));
      chk({tag, "_flush"}, 16'(bus.Flush), 16'(mcnt != 0));
   endtask

   // One instruction: check combinational outputs, advance the model, clock, check registers.
   task automatic step(input string tag);
      int a, b, res, sh;
      longint wide;
      bit zn_v, c_v, c_alu, flush, cond, taken;
      #1;
      a = int'(bus.Reg1);
      b = bus.ALU_src ? int'(bus.instr) : int'(bus.Reg2);
      flush = (mcnt != 0);
      case (bus.Instruction[1:0])
         2'd0:    cond = mz;
         2'd1:    cond = mn;
         2'd2:    cond = mc;
         default: cond = 1'b1;
      endcase
      taken = bus.Branch && !flush && cond;
      chk({tag, "_btaken"}, 16'(bus.BranchTaken), 16'(taken));
      chk({tag, "_btarget"}, bus.BranchTarget, 16'(a));
      chk({tag, "_flush_pre"}, 16'(bus.Flush), 16'(flush));

      zn_v = 0; c_v = 0; c_alu = 0; sh = b % 16; res = a;
      case (int'(bus.aluSignals))
         1: begin res = 65535 - a; zn_v = 1; end
         2: begin res = a + 1; c_alu = (res > 65535); res = res % 65536; zn_v = 1; c_v = 1; end
         3: begin c_alu = (a == 0); res = (a + 65535) % 65536; zn_v = 1; c_v = 1; end
         4: begin res = a + b; c_alu = (res > 65535); res = res % 65536; zn_v = 1; c_v = 1; end
         5: begin c_alu = (a < b); res = (a - b + 65536) % 65536; zn_v = 1; c_v = 1; end
         6: begin res = a & b; zn_v = 1; end
         7: begin res = a | b; zn_v = 1; end
         8: begin
            wide = longint'(a) * (longint'(1) << sh);
            res = int'(wide % 65536); c_alu = ((wide / 65536) % 2) == 1;
            zn_v = 1; c_v = (sh != 0);
         end
         9: begin
            res = a / (1 << sh);
            if (sh != 0) c_alu = ((a / (1 << (sh - 1))) % 2) == 1;
            zn_v = 1; c_v = (sh != 0);
         end
         10: res = b;
         default: res = a;
      endcase

      e_res = res; e_store = int'(bus.Reg2); e_rd = int'(bus.RegDestination);
      e_rw = bus.RW && !flush; e_mr = bus.MR && !flush; e_mw = bus.MW && !flush;
      e_mtr = bus.MTR;
      if (!flush) begin
         if (zn_v) begin mz = (res == 0); mn = (res >= 32768); end
         if (bus.SetC && bus.CLRC) ;
         else if (bus.SetC) mc = 1;
         else if (bus.CLRC) mc = 0;
         else if (c_v) mc = c_alu;
         if (taken) begin
            case (bus.Instruction[1:0])
               2'd0: mz = 0;
               2'd1: mn = 0;
               2'd2: mc = 0;
               default: ;
            endcase
         end
      end
      if (taken) mcnt = 2;
      else if (mcnt > 0) mcnt = mcnt - 1;

      @(posedge clk);
      #1;
      check_regs(tag);
   endtask

   initial begin
      rst = 1'b1;
      nop();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_regs("reset");
      rst = 1'b0;

      // ADD overflow wraps to zero with carry
      nop(); bus.Reg1 = 16'hFFFF; bus.Reg2 = 16'h0001; bus.aluSignals = ALU_ADD;
      bus.RW = 1'b1; bus.RegDestination = 3'd5; step("t1");
      chk("t1_res_const", bus.ResultOut, 16'h0000);
      chk("t1_ccr_const", 16'(bus.CCR), 16'(3'b101));

      // SUB with immediate, borrow; then illegal SetC+CLRC holds C
      nop(); bus.Reg1 = 16'h0003; bus.instr = 16'h0005; bus.ALU_src = 1'b1;
      bus.aluSignals = ALU_SUB; step("t2");
      chk("t2_res_const", bus.ResultOut, 16'hFFFE);
      chk("t2_ccr_const", 16'(bus.CCR), 16'(3'b110));
      nop(); bus.SetC = 1'b1; bus.CLRC = 1'b1; step("t2b");
      chk("t2b_c_const", 16'(bus.CCR[CCR_C]), 16'h1);

      // JZ taken: Z cleared, two flush cycles
      nop(); bus.Reg1 = 16'hFFFF; bus.Reg2 = 16'h0001; bus.aluSignals = ALU_ADD; step("t3a");
      nop(); bus.Branch = 1'b1; bus.Instruction = 5'b00000; bus.Reg1 = 16'h0040;
      #1;
      chk("t3_btaken_const", 16'(bus.BranchTaken), 16'h1);
      chk("t3_btarget_const", bus.BranchTarget, 16'h0040);
      step("t3");
      chk("t3_z_const", 16'(bus.CCR[CCR_Z]), 16'h0);
      nop(); step("t3f1");
      chk("t3_flush1_const", 16'(bus.Flush), 16'h1);
      nop(); step("t3f2");
      chk("t3_flush2_const", 16'(bus.Flush), 16'h0);

      // JMP, then JZ with Z=1 arriving in the flush shadow
      nop(); bus.Reg1 = 16'hFFFF; bus.Reg2 = 16'h0001; bus.aluSignals = ALU_ADD; step("t4a");
      nop(); bus.Branch = 1'b1; bus.Instruction = 5'b00011; bus.Reg1 = 16'h1234; step("t4");
      nop(); bus.Branch = 1'b1; bus.Instruction = 5'b00000; bus.Reg1 = 16'h0080;
      bus.RW = 1'b1; bus.MR = 1'b1; bus.MW = 1'b1; bus.MTR = 1'b1; bus.Reg2 = 16'hBEEF;
      #1;
      chk("t4_ignored_const", 16'(bus.BranchTaken), 16'h0);
      step("t4b");
      chk("t4_z_const", 16'(bus.CCR[CCR_Z]), 16'h1);
      chk("t4_rwmw_const", 16'({bus.RWOut, bus.MWOut}), 16'h0);
      nop(); step("t4c");
      chk("t4_flush_const", 16'(bus.Flush), 16'h0);

      // SHL carries out bit 15; shift by 0 keeps C
      nop(); bus.Reg1 = 16'h8001; bus.Reg2 = 16'h0001; bus.aluSignals = ALU_SHL; step("t5");
      chk("t5_res_const", bus.ResultOut, 16'h0002);
      chk("t5_c_const", 16'(bus.CCR[CCR_C]), 16'h1);
      nop(); bus.Reg1 = 16'h8001; bus.Reg2 = 16'h0000; bus.aluSignals = ALU_SHL; step("t5b");
      chk("t5b_c_const", 16'(bus.CCR[CCR_C]), 16'h1);
      nop(); bus.Reg1 = 16'h0003; bus.Reg2 = 16'h0002; bus.aluSignals = ALU_SHR; step("t5c");

      // Async reset in the second flush cycle
      nop(); bus.Branch = 1'b1; bus.Instruction = 5'b00011; bus.Reg1 = 16'h00F0;
      bus.Reg2 = 16'h7777; bus.RW = 1'b1; step("t6");
      nop(); bus.Reg1 = 16'h0055; step("t6f1");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_regs("t6_rst");
      @(posedge clk);
      #1;
      check_regs("t6_hold");
      rst = 1'b0;
      nop(); bus.Reg1 = 16'h0010; bus.aluSignals = ALU_INC; step("t6_resume");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         nop();
         bus.Reg1 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
         bus.Reg2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
         bus.instr = 16'($urandom);
         bus.aluSignals = 4'($urandom);
         bus.ALU_src = 1'($urandom);
         bus.Branch = ($urandom_range(0, 3) == 0);
         bus.Instruction = 5'($urandom);
         bus.SetC = ($urandom_range(0, 7) == 0);
         bus.CLRC = ($urandom_range(0, 7) == 0);
         bus.RW = 1'($urandom); bus.MR = 1'($urandom);
         bus.MW = 1'($urandom); bus.MTR = 1'($urandom);
         bus.RegDestination = 3'($urandom);
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
